// File: rtl/tensor_pkg.sv
// tensor_pkg
//   Shared constants and types for the tensor dot-product drain path.
//   Tile geometry (NUM_ROWS x NUM_COLS elements of DATA_W bits), tag width,
//   row/tile typedefs and the serializer state enum.
//   NUM_ROWS must be at least 2 so that row 0 and the last row are distinct beats.
package tensor_pkg;

    localparam int NUM_ROWS  = 4;
    localparam int NUM_COLS  = 4;
    localparam int DATA_W    = 32;
    localparam int TAG_W     = 8;
    localparam int ROW_IDX_W = $clog2(NUM_ROWS);

    // One row: element c occupies bits [c*DATA_W +: DATA_W].
    typedef logic [NUM_COLS*DATA_W-1:0] tensor_row_t;

    // Whole tile, row-major: tile[r] is row r, row 0 in the low bits.
    typedef tensor_row_t [NUM_ROWS-1:0] tensor_tile_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/tensor_d_serializer_if.sv
// tensor_d_serializer_if
//   Bundles both handshakes of the serializer:
//     capture side : valid_in / ready_in / stall_out with tag_in and D_tile
//     drain side   : valid_out / ready_out with row_idx, row_data, tag_out, last_out
//   Handshake rule (both sides): a transfer happens on a rising clk edge where
//   valid and ready are both 1. A source holding valid=1 keeps its payload
//   stable and does not drop valid until that transfer happens.
//   master : the serializer.  slave : the DPU plus writeback port (or a bench).
interface tensor_d_serializer_if;
    import tensor_pkg::*;

    logic                 valid_in;
    logic                 ready_in;
    logic                 stall_out;
    logic [TAG_W-1:0]     tag_in;
    tensor_tile_t         D_tile;

    logic                 valid_out;
    logic                 ready_out;
    logic [ROW_IDX_W-1:0] row_idx;
    tensor_row_t          row_data;
    logic [TAG_W-1:0]     tag_out;
    logic                 last_out;

    modport master (
        input  valid_in, tag_in, D_tile, ready_out,
        output ready_in, stall_out, valid_out, row_idx, row_data, tag_out, last_out
    );

    modport slave (
        output valid_in, tag_in, D_tile, ready_out,
        input  ready_in, stall_out, valid_out, row_idx, row_data, tag_out, last_out
    );

endinterface

// File: rtl/tensor_d_serializer.sv
// tensor_d_serializer
//   Captures one 4x4 FP32 result tile plus tag in a single cycle and drains it
//   one row per cycle toward the register-file writeback port.
//   Ports:
//     clk       : single clock, rising edge
//     reset     : asynchronous, active-low
//     bus       : tensor_d_serializer_if.master (capture + drain handshakes)
//     busy      : a tile is held (state SEND)
//     state_dbg : current FSM state for observation
module tensor_d_serializer
    import tensor_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    tensor_d_serializer_if.master        bus,
    output logic                         busy,
    output state_t                       state_dbg
);

    state_t               state_q, state_d;
    logic [ROW_IDX_W-1:0] row_q, row_d;
    tensor_tile_t         tile_q;
    logic [TAG_W-1:0]     tag_q;

    logic last_row;
    logic handshake;
    logic capture;

    assign last_row  = (row_q == ROW_IDX_W'(NUM_ROWS - 1));
    assign handshake = bus.valid_out & bus.ready_out;
    assign capture   = bus.valid_in & bus.ready_in;

    // Accepting a new tile while still in SEND is only allowed on the cycle the
    // last row leaves, which is why ready_out feeds ready_in combinationally.
    assign bus.ready_in  = (state_q == IDLE) |
                           ((state_q == SEND) & last_row & bus.ready_out);
    assign bus.stall_out = bus.valid_in & ~bus.ready_in;

    assign bus.valid_out = (state_q == SEND);
    assign bus.row_idx   = row_q;
    assign bus.row_data  = tile_q[row_q];
    assign bus.tag_out   = tag_q;
    assign bus.last_out  = (state_q == SEND) & last_row;

    assign busy      = (state_q == SEND);
    assign state_dbg = state_q;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        case (state_q)
            IDLE: begin
                if (capture) begin
                    state_d = SEND;
                    row_d   = '0;
                end
            end
            SEND: begin
                if (handshake) begin
                    if (last_row) begin
                        // A tile waiting on the last-row handshake is taken
                        // immediately so back-to-back tiles have no bubble.
                        row_d   = '0;
                        state_d = capture ? SEND : IDLE;
                    end else begin
                        row_d = row_q + ROW_IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                row_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            row_q   <= '0;
            tile_q  <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            if (capture) begin
                tile_q <= bus.D_tile;
                tag_q  <= bus.tag_in;
            end
        end
    end

    a_valid_known: assert property (@(posedge clk) disable iff (!reset)
        !$isunknown(bus.valid_out));

    a_beat_stable: assert property (@(posedge clk) disable iff (!reset)
        (bus.valid_out && !bus.ready_out) |=>
            (bus.valid_out && $stable(bus.row_data) && $stable(bus.row_idx) &&
             $stable(bus.tag_out) && $stable(bus.last_out)));

endmodule

// File: tb/tb_tensor_d_serializer.sv
module tb_tensor_d_serializer;
    import tensor_pkg::*;

    logic   clk;
    logic   reset;
    logic   busy;
    state_t state_dbg;

    int n_assert = 0;
    int n_fail   = 0;

    tensor_d_serializer_if bus ();

    tensor_d_serializer dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    function automatic tensor_tile_t make_tile(input logic [31:0] base);
        tensor_tile_t t;
        for (int r = 0; r < NUM_ROWS; r++)
            for (int c = 0; c < NUM_COLS; c++)
                t[r][c*DATA_W +: DATA_W] = base + 32'(r * 16 + c);
        return t;
    endfunction

    function automatic tensor_row_t exp_row(input logic [31:0] base, input int r);
        tensor_row_t v;
        for (int c = 0; c < NUM_COLS; c++)
            v[c*DATA_W +: DATA_W] = base + 32'(r * 16 + c);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past a rising edge; inputs may be changed right after.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    task automatic chk_beat(input string tag, input logic [31:0] base, input int r,
                            input logic [7:0] tg);
        chk({tag, "_valid"}, 128'(bus.valid_out), 128'(1));
        chk({tag, "_idx"},   128'(bus.row_idx),   128'(r));
        chk({tag, "_data"},  128'(bus.row_data),  128'(exp_row(base, r)));
        chk({tag, "_tag"},   128'(bus.tag_out),   128'(tg));
        chk({tag, "_last"},  128'(bus.last_out),  128'(r == NUM_ROWS - 1));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset         = 1'b0;
        bus.valid_in  = 1'b0;
        bus.tag_in    = '0;
        bus.D_tile    = '0;
        bus.ready_out = 1'b1;

        // Reset state
        #2;
        chk("rst_valid", 128'(bus.valid_out), 128'(0));
        chk("rst_busy",  128'(busy),          128'(0));
        chk("rst_last",  128'(bus.last_out),  128'(0));
        chk("rst_idx",   128'(bus.row_idx),   128'(0));
        chk("rst_data",  128'(bus.row_data),  128'(0));
        chk("rst_tag",   128'(bus.tag_out),   128'(0));
        chk("rst_state", 128'(state_dbg),     128'(IDLE));
        #10;
        reset = 1'b1;
        settle();
        chk("rst_ready_in", 128'(bus.ready_in), 128'(1));

        // Single tile, ready_out held high
        bus.valid_in = 1'b1;
        bus.D_tile   = make_tile(32'h0);
        bus.tag_in   = 8'h5A;
        settle();
        chk("t1_ready_c0", 128'(bus.ready_in),  128'(1));
        chk("t1_stall_c0", 128'(bus.stall_out), 128'(0));
        cyc();
        bus.valid_in = 1'b0;
        settle();
        chk("t1_row0_hand", 128'(bus.row_data), 128'h00000003_00000002_00000001_00000000);
        chk("t1_state",     128'(state_dbg),    128'(SEND));
        for (int r = 0; r < NUM_ROWS; r++) begin
            chk_beat("t1_beat", 32'h0, r, 8'h5A);
            if (r == NUM_ROWS - 1)
                chk("t1_row3_hand", 128'(bus.row_data), 128'h00000033_00000032_00000031_00000030);
            cyc();
        end
        chk("t1_busy_end",  128'(busy),          128'(0));
        chk("t1_valid_end", 128'(bus.valid_out), 128'(0));

        // Back-to-back tiles with valid_in held high
        bus.valid_in = 1'b1;
        bus.D_tile   = make_tile(32'h100);
        bus.tag_in   = 8'h11;
        settle();
        chk("b2b_ready_c0", 128'(bus.ready_in), 128'(1));
        cyc();
        bus.D_tile = make_tile(32'h200);
        bus.tag_in = 8'h22;
        for (int k = 1; k <= 3; k++) begin
            settle();
            chk_beat("b2b_t0", 32'h100, k - 1, 8'h11);
            chk("b2b_ready_lo", 128'(bus.ready_in),  128'(0));
            chk("b2b_stall_hi", 128'(bus.stall_out), 128'(1));
            cyc();
        end
        settle();
        chk_beat("b2b_t0", 32'h100, 3, 8'h11);
        chk("b2b_ready_c4", 128'(bus.ready_in),  128'(1));
        chk("b2b_stall_c4", 128'(bus.stall_out), 128'(0));
        cyc();
        bus.valid_in = 1'b0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            settle();
            chk_beat("b2b_t1", 32'h200, r, 8'h22);
            if (r < NUM_ROWS - 1) chk("b2b_t1_ready", 128'(bus.ready_in), 128'(0));
            cyc();
        end
        chk("b2b_busy_end", 128'(busy), 128'(0));

        // Stall on row 1 for three cycles
        bus.valid_in = 1'b1;
        bus.D_tile   = make_tile(32'h400);
        bus.tag_in   = 8'h33;
        cyc();
        bus.valid_in = 1'b0;
        settle();
        chk_beat("stl_r0", 32'h400, 0, 8'h33);
        cyc();
        bus.ready_out = 1'b0;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk_beat("stl_hold", 32'h400, 1, 8'h33);
            chk("stl_ready_in", 128'(bus.ready_in), 128'(0));
            cyc();
        end
        bus.ready_out = 1'b1;
        settle();
        chk_beat("stl_r1_rel", 32'h400, 1, 8'h33);
        cyc();
        settle();
        chk_beat("stl_r2", 32'h400, 2, 8'h33);
        cyc();
        settle();
        chk_beat("stl_r3", 32'h400, 3, 8'h33);
        cyc();
        chk("stl_done", 128'(busy), 128'(0));

        // Stall on the last row while a new tile is pending
        bus.valid_in = 1'b1;
        bus.D_tile   = make_tile(32'h800);
        bus.tag_in   = 8'h44;
        cyc();
        bus.valid_in = 1'b0;
        cyc();
        cyc();
        cyc();
        bus.ready_out = 1'b0;
        bus.valid_in  = 1'b1;
        bus.D_tile    = make_tile(32'hC00);
        bus.tag_in    = 8'h55;
        for (int k = 0; k < 2; k++) begin
            settle();
            chk_beat("lst_hold", 32'h800, 3, 8'h44);
            chk("lst_ready_in", 128'(bus.ready_in),  128'(0));
            chk("lst_stall",    128'(bus.stall_out), 128'(1));
            cyc();
        end
        bus.ready_out = 1'b1;
        settle();
        chk("lst_ready_rel", 128'(bus.ready_in),  128'(1));
        chk("lst_stall_rel", 128'(bus.stall_out), 128'(0));
        cyc();
        bus.valid_in = 1'b0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            settle();
            chk_beat("lst_new", 32'hC00, r, 8'h55);
            cyc();
        end
        chk("lst_done", 128'(busy), 128'(0));

        // Asynchronous reset in the middle of a drain
        bus.valid_in = 1'b1;
        bus.D_tile   = make_tile(32'h1000);
        bus.tag_in   = 8'h66;
        cyc();
        bus.valid_in = 1'b0;
        cyc();
        cyc();
        settle();
        chk_beat("ar_pre", 32'h1000, 2, 8'h66);
        #1;
        reset = 1'b0;
        #1;
        chk("ar_valid", 128'(bus.valid_out), 128'(0));
        chk("ar_busy",  128'(busy),          128'(0));
        chk("ar_idx",   128'(bus.row_idx),   128'(0));
        chk("ar_data",  128'(bus.row_data),  128'(0));
        chk("ar_tag",   128'(bus.tag_out),   128'(0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("ar_post_valid", 128'(bus.valid_out), 128'(0));
            chk("ar_post_ready", 128'(bus.ready_in),  128'(1));
        end
        bus.valid_in = 1'b1;
        bus.D_tile   = make_tile(32'h2000);
        bus.tag_in   = 8'h77;
        cyc();
        bus.valid_in = 1'b0;
        settle();
        chk_beat("ar_next", 32'h2000, 0, 8'h77);
        for (int k = 0; k < NUM_ROWS; k++) cyc();
        chk("ar_next_done", 128'(busy), 128'(0));

        // Idle for 20 cycles
        for (int k = 0; k < 20; k++) begin
            cyc();
            chk("idle_valid", 128'(bus.valid_out), 128'(0));
            chk("idle_busy",  128'(busy),          128'(0));
            chk("idle_ready", 128'(bus.ready_in),  128'(1));
            chk("idle_stall", 128'(bus.stall_out), 128'(0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/tensor_d_serializer.md
Name: tensor_d_serializer

Overview:
- Drain side of the tensor dot-product unit. Captures one completed 4x4 FP32 result tile (D_tile) plus its writeback tag in a single cycle.
- Emits the tile one row per cycle toward the register-file writeback port, using a valid/ready handshake.
- Generates the back-pressure (`stall_out`) that freezes the tensor DPU pipeline while a tile is still draining.

Parameters:
- NUM_ROWS, 4, rows per tile; one output beat per row.
- NUM_COLS, 4, elements per row.
- DATA_W, 32, element width in bits (FP32).
- TAG_W, 8, writeback tag width (warp id / destination register), carried through unchanged.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- valid_in  input  1  DPU result valid.
- ready_in  output  1  serializer can capture a tile this cycle.
- stall_out  output  1  equals valid_in & ~ready_in; drives the DPU stall input.
- tag_in  input  TAG_W  tag accompanying the tile.
- D_tile  input  NUM_ROWS*NUM_COLS*DATA_W  result tile, row-major [row][col][bit].
- valid_out  output  1  row beat valid.
- ready_out  input  1  writeback port accepts the beat.
- row_idx  output  $clog2(NUM_ROWS)  index of the current row.
- row_data  output  NUM_COLS*DATA_W  row contents [col][bit].
- tag_out  output  TAG_W  tag of the tile being drained.
- last_out  output  1  current beat is row NUM_ROWS-1.
- busy  output  1  a tile is held (state SEND).

Behaviour:
- Reset values (reset=0, effective immediately and asynchronously):
  - state=IDLE, row counter=0, valid_out=0, last_out=0, busy=0.
  - row_data, tag_out and the tile buffer are cleared to 0.
  - ready_in=1 as soon as reset deasserts.
- States:
  - IDLE: ready_in=1, valid_out=0.
    - valid_in=1 captures D_tile and tag_in into the buffer, clears the counter, and moves to SEND.
  - SEND: valid_out=1; row_data=buffer[row counter]; row_idx=counter; last_out=(counter==NUM_ROWS-1).
    - Handshake is valid_out & ready_out; on handshake the counter increments.
    - Handshake on the last row:
      - with valid_in=1: capture the new tile and tag, counter=0, stay in SEND (no bubble);
      - with valid_in=0: go to IDLE, counter=0.
- ready_in = (state==IDLE) | (state==SEND & last_out & ready_out).
  - This is the only combinational path from ready_out to ready_in.
- Latency: a tile captured at edge N presents row 0 at cycle N+1. The last row's handshake occurs no earlier than cycle N+NUM_ROWS.
- Throughput: one tile per NUM_ROWS cycles with ready_out held high.
- Output stability:
  - Once valid_out=1, row_idx, row_data, tag_out and last_out stay stable until the handshake.
  - valid_out never drops without a handshake.
- Back-pressure:
  - ready_out=0 holds the current beat indefinitely.
  - valid_in asserted while ready_in=0 is not captured; stall_out=1 until capture.
- Counter: wraps only through the explicit reset to 0 on the last-row handshake; it never exceeds NUM_ROWS-1.
- Reset mid-drain: the held tile is discarded, with no partial beats after reset deasserts. The DPU must re-present the tile or drop it; this block does not retain it.
- NUM_ROWS must be ≥2. Simulation asserts:
  - no X on valid_out after reset;
  - beat stability under stall.

Decomposition:
- Shared package `tensor_pkg`: DATA_W, NUM_ROWS, NUM_COLS localparams; typedefs `tensor_row_t` (NUM_COLS*DATA_W) and `tensor_tile_t` (NUM_ROWS rows); state enum {IDLE, SEND}.
- No sub-module required. The row mux is an indexed read of the buffer; the counter and FSM are inline.

Test Plan:
- Single tile, ready_out=1: element[r][c]=r*16+c, tag_in=0x5A at cycle 0.
  - Required: beats at cycles 1-4 with row_idx 0..3, row_data words {16r..16r+3}, tag_out=0x5A, last_out only at cycle 4, busy low at cycle 5.
- Back-to-back: valid_in held high with tiles T0, T1.
  - Required: ready_in=1 at cycles 0 and 4 only; T1 row 0 appears at cycle 5; 8 consecutive beats with no gap; stall_out=1 at cycles 1-3.
- Stall: ready_out=0 during cycles 2-4 of a tile.
  - Required: row 1 is held stable through cycle 4 with valid_out=1 and identical row_data; row 2 follows at cycle 6; total drain is 7 cycles.
- Stall on last row with a pending tile: ready_out=0 while last_out=1, valid_in=1.
  - Required: ready_in=0 and stall_out=1; capture happens on the cycle ready_out returns to 1.
- Async reset mid-drain: reset driven low between edges at row 2.
  - Required: valid_out and busy go 0 immediately; after release, no beats appear; ready_in=1; the next tile starts at row 0.
- Idle: valid_in=0 for 20 cycles.
  - Required: valid_out=0, busy=0, ready_in=1, stall_out=0 throughout.
